// File: rtl/if_fetch_ctrl.sv
// Fetch-stage controller for the IF stage.
// Drives the PC register (npc/pc_en/pc_stall), runs a single-outstanding
// request/response handshake to instruction memory, and presents fetched
// instructions to IF/ID through a registered slot backed by a one-entry
// hold buffer. EX redirects flush the slot and the buffer; a response that
// belongs to a killed fetch is swallowed in DROP.
//
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   pc                current PC from the PC register
//   npc               next PC (redirect target or pc+4)
//   pc_en, pc_stall   PC register enable / stall
//   redirect_valid    EX redirect (taken branch/jump)
//   redirect_target   redirect address
//   id_stall          ID cannot accept this cycle
//   imem_req_*        fetch request channel (valid/addr out, ready in)
//   imem_resp_*       fetch response channel (valid/data in)
//   if_valid/pc/inst  instruction presented to IF/ID
module if_fetch_ctrl #(
  parameter logic [31:0] NOP_INST = 32'h03400000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc,
  output logic [31:0] npc,
  output logic        pc_en,
  output logic        pc_stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        id_stall,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic        slot_free;
  logic        load_resp;   // response goes straight into the slot
  logic        load_hold;   // buffered instruction moves into the slot
  logic        stash;       // response parked in the hold buffer
  logic        advance;
  logic        hold_valid;
  logic [31:0] hold_pc;
  logic [31:0] hold_inst;

  assign pc_en          = !rst;
  assign npc            = redirect_valid ? redirect_target : pc + 32'd4;
  assign pc_stall       = !advance;
  assign imem_req_valid = (state == S_REQ);
  assign imem_req_addr  = pc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_REQ;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_resp = 1'b0;
    load_hold = 1'b0;
    stash     = 1'b0;
    slot_free = !if_valid || !id_stall;

    if (redirect_valid) begin
      // A request accepted this cycle, or one still in flight, will return
      // data for the killed path; DROP absorbs it unless it arrives now.
      unique case (state)
        S_REQ:          state_nxt = imem_req_ready  ? S_DROP : S_REQ;
        S_WAIT, S_DROP: state_nxt = imem_resp_valid ? S_REQ  : S_DROP;
        S_HOLD:         state_nxt = S_REQ;
        default:        state_nxt = S_REQ;
      endcase
    end else begin
      unique case (state)
        S_REQ: begin
          if (imem_req_ready) state_nxt = S_WAIT;
        end
        S_WAIT: begin
          if (imem_resp_valid) begin
            if (slot_free) begin
              load_resp = 1'b1;
              state_nxt = S_REQ;
            end else begin
              stash     = 1'b1;
              state_nxt = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (slot_free && hold_valid) begin
            load_hold = 1'b1;
            state_nxt = S_REQ;
          end
        end
        S_DROP: begin
          if (imem_resp_valid) state_nxt = S_REQ;
        end
        default: state_nxt = S_REQ;
      endcase
    end

    advance = redirect_valid || load_resp || load_hold;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid   <= 1'b0;
      if_pc      <= '0;
      if_inst    <= NOP_INST;
      hold_valid <= 1'b0;
      hold_pc    <= '0;
      hold_inst  <= '0;
    end else if (redirect_valid) begin
      if_valid   <= 1'b0;
      if_inst    <= NOP_INST;
      hold_valid <= 1'b0;
    end else begin
      if (load_resp) begin
        if_valid <= 1'b1;
        if_pc    <= pc;
        if_inst  <= imem_resp_data;
      end else if (load_hold) begin
        if_valid <= 1'b1;
        if_pc    <= hold_pc;
        if_inst  <= hold_inst;
      end else if (if_valid && !id_stall) begin
        if_valid <= 1'b0;
      end

      if (stash) begin
        hold_valid <= 1'b1;
        hold_pc    <= pc;
        hold_inst  <= imem_resp_data;
      end else if (load_hold) begin
        hold_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl. The bench plays the PC register and the
// instruction memory; every response expected to reach IF/ID is pushed as
// {pc, inst} onto a scoreboard queue and popped whenever the slot loads.
module tb_if_fetch_ctrl;

  localparam logic [31:0] NOP   = 32'h03400000;
  localparam logic [31:0] RSTPC = 32'h1c000000;

  logic        clk;
  logic        rst;
  logic [31:0] pc;
  logic [31:0] npc;
  logic        pc_en;
  logic        pc_stall;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_stall;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;

  int unsigned n_assert;
  int unsigned n_fail;
  logic        watch_dead;
  logic [63:0] q[$];

  if_fetch_ctrl #(.NOP_INST(NOP)) dut (
    .clk             (clk),
    .rst             (rst),
    .pc              (pc),
    .npc             (npc),
    .pc_en           (pc_en),
    .pc_stall        (pc_stall),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .id_stall        (id_stall),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .if_valid        (if_valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    #1;
  endtask

  // One clock: sample pre-edge values at negedge, update the PC model at the
  // edge, then detect slot loads and score them against the queue.
  task automatic tick();
    logic        pv, ps;
    logic [31:0] nxt;
    logic [63:0] e;
    @(negedge clk);
    pv  = if_valid;
    ps  = id_stall;
    nxt = (pc_en && !pc_stall) ? npc : pc;
    @(posedge clk);
    #1;
    pc = nxt;
    if (if_valid && (!pv || !ps)) begin
      chk("sb_expected_load", {31'd0, (q.size() != 0)}, 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        chk("sb_pc", if_pc, e[63:32]);
        chk("sb_inst", if_inst, e[31:0]);
      end
    end
    if (watch_dead) begin
      n_assert++;
      assert (if_inst !== 32'hDEADBEEF) else begin
        n_fail++;
        $error("FAIL killed_inst_visible: observed %h expected not deadbeef", if_inst);
      end
    end
  endtask

  task automatic fetch(input logic [31:0] data);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = data;
    q.push_back({pc, data});
    tick();
    imem_resp_valid = 1'b0;
  endtask

  initial begin
    n_assert        = 0;
    n_fail          = 0;
    watch_dead      = 1'b0;
    rst             = 1'b1;
    pc              = RSTPC;
    redirect_valid  = 1'b0;
    redirect_target = '0;
    id_stall        = 1'b0;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;

    // Reset state
    tick();
    tick();
    chk("rst_pc_en", {31'd0, pc_en}, 32'd0);
    chk("rst_if_valid", {31'd0, if_valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_inst", if_inst, NOP);
    rst = 1'b0;
    settle();
    chk("pc_en", {31'd0, pc_en}, 32'd1);

    // 1: first fetch, 1-cycle response
    chk("t1_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t1_req_addr", imem_req_addr, 32'h1c000000);
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h02800421;
    q.push_back({pc, 32'h02800421});
    settle();
    chk("t1_npc", npc, 32'h1c000004);
    chk("t1_pc_stall", {31'd0, pc_stall}, 32'd0);
    tick();
    imem_resp_valid = 1'b0;
    chk("t1_if_valid", {31'd0, if_valid}, 32'd1);

    // 2: request back-pressure
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("t2_req_valid", {31'd0, imem_req_valid}, 32'd1);
      chk("t2_req_addr", imem_req_addr, 32'h1c000004);
      chk("t2_pc_stall", {31'd0, pc_stall}, 32'd1);
      tick();
    end
    chk("t2_drained", {31'd0, if_valid}, 32'd0);
    fetch(32'h00100000);

    // 3: hold buffer under id_stall
    id_stall       = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h00200000;
    settle();
    chk("t3_pc_stall_resp", {31'd0, pc_stall}, 32'd1);
    tick();
    imem_resp_valid = 1'b0;
    settle();
    chk("t3_hold_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("t3_hold_pc_stall", {31'd0, pc_stall}, 32'd1);
    chk("t3_slot_pc", if_pc, 32'h1c000004);
    chk("t3_slot_inst", if_inst, 32'h00100000);
    tick();
    id_stall = 1'b0;
    q.push_back({32'h1c000008, 32'h00200000});
    settle();
    chk("t3_release_pc_stall", {31'd0, pc_stall}, 32'd0);
    chk("t3_release_npc", npc, 32'h1c00000c);
    tick();
    settle();
    chk("t3_next_req_addr", imem_req_addr, 32'h1c00000c);

    // 4: redirect in WAIT, late response dropped
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h1c000100;
    settle();
    chk("t4_npc", npc, 32'h1c000100);
    chk("t4_pc_stall", {31'd0, pc_stall}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    watch_dead     = 1'b1;
    settle();
    chk("t4_if_valid", {31'd0, if_valid}, 32'd0);
    chk("t4_if_inst", if_inst, NOP);
    chk("t4_drop_req_valid", {31'd0, imem_req_valid}, 32'd0);
    tick();
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hDEADBEEF;
    tick();
    imem_resp_valid = 1'b0;
    settle();
    chk("t4_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t4_req_addr", imem_req_addr, 32'h1c000100);
    fetch(32'h00300000);

    // 5a: redirect coincident with response in WAIT
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD00001;
    redirect_valid  = 1'b1;
    redirect_target = 32'h1c000200;
    settle();
    chk("t5a_npc", npc, 32'h1c000200);
    chk("t5a_pc_stall", {31'd0, pc_stall}, 32'd0);
    tick();
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b0;
    settle();
    chk("t5a_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t5a_req_addr", imem_req_addr, 32'h1c000200);
    chk("t5a_if_valid", {31'd0, if_valid}, 32'd0);

    // 5b: redirect in HOLD with id_stall held
    fetch(32'h00400000);
    id_stall       = 1'b1;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'hBAD00002;
    tick();
    imem_resp_valid = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h1c000300;
    settle();
    chk("t5b_npc", npc, 32'h1c000300);
    chk("t5b_pc_stall", {31'd0, pc_stall}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    settle();
    chk("t5b_if_valid", {31'd0, if_valid}, 32'd0);
    chk("t5b_if_inst", if_inst, NOP);
    chk("t5b_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t5b_req_addr", imem_req_addr, 32'h1c000300);
    id_stall = 1'b0;
    tick();
    tick();

    // 6: PC wrap, then asynchronous reset mid-WAIT
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFFFFFC;
    tick();
    redirect_valid = 1'b0;
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b1;
    imem_resp_data  = 32'h12345678;
    q.push_back({pc, 32'h12345678});
    settle();
    chk("t6_wrap_npc", npc, 32'h00000000);
    tick();
    imem_resp_valid = 1'b0;
    id_stall        = 1'b1;
    imem_req_ready  = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    settle();
    chk("t6_pre_if_valid", {31'd0, if_valid}, 32'd1);
    chk("t6_pre_req_valid", {31'd0, imem_req_valid}, 32'd0);
    rst = 1'b1;
    #1;
    chk("t6_async_if_valid", {31'd0, if_valid}, 32'd0);
    chk("t6_async_if_inst", if_inst, NOP);
    chk("t6_async_pc_en", {31'd0, pc_en}, 32'd0);
    pc       = RSTPC;
    id_stall = 1'b0;
    tick();
    rst = 1'b0;
    settle();
    chk("t6_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t6_req_addr", imem_req_addr, RSTPC);
    fetch(32'h02800421);
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
